// File: rtl/bcd_updown_counter_disp.sv
// bcd_updown_counter_disp
//   N-digit BCD up/down counter driven by two raw active-low pushbuttons.
//   Each key runs through a 2-FF synchroniser, a debouncer and a press-edge
//   detector. The count drives per-digit active-low 7-segment decoders
//   ({g,f,e,d,c,b,a}) and a one-cycle wrap pulse.
//   Optional feature macro: HOLD_REPEAT_EN (auto-repeat while a key is held).
//   When the macro is undefined, each press makes one step, no hold timers
//   are built and the REPEAT_* parameters have no effect.
module bcd_updown_counter_disp #(
  parameter int NUM_DIGITS      = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_up,
  input  logic                    key_dn,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    wrap
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Key index 0 = up, 1 = down; all key state is active-low (1 = released).
  logic [1:0]      key_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_prev_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [1:0]      press;
  logic [1:0]      step;

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic                    wrap_q, wrap_d;
  logic                    up_en, dn_en, chain;

  assign key_raw = {key_dn, key_up};

  // Two-flop synchroniser for the asynchronous key inputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q       <= 2'b11;
      deb_prev_q  <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      deb_prev_q <= deb_q;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == deb_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_LAST) begin
          deb_q[k]    <= sync2_q[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // A press is the debounced 1->0 transition; release produces nothing.
  assign press = deb_prev_q & ~deb_q;

`ifdef HOLD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q [2];
  logic [1:0]       rpt_on_q;
  logic [1:0]       rpt_fire;

  // Repeat fires REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD.
  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    rpt_fire = '0;
    for (int k = 0; k < 2; k++) begin
      if (!deb_q[k]) begin
        rpt_fire[k] = rpt_on_q[k] ? (rpt_cnt_q[k] == RPT_W'(REPEAT_PERIOD))
                                  : (rpt_cnt_q[k] == RPT_W'(REPEAT_DELAY));
      end
    end
  end

  // Hold timers count while the debounced key stays pressed; release clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q[0] <= '0;
      rpt_cnt_q[1] <= '0;
      rpt_on_q     <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (deb_q[k]) begin
          rpt_cnt_q[k] <= '0;
          rpt_on_q[k]  <= 1'b0;
        end else if (rpt_fire[k]) begin
          rpt_cnt_q[k] <= RPT_W'(1);
          rpt_on_q[k]  <= 1'b1;
        end else begin
          rpt_cnt_q[k] <= rpt_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign step = press | rpt_fire;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign step = press;
`endif

  // Simultaneous up and down steps cancel each other.
  assign up_en = step[0] & ~step[1];
  assign dn_en = step[1] & ~step[0];

  // Next count: ripple carry (up) or borrow (down) through the BCD digits.
  always_comb begin
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    chain  = 1'b1;
    if (up_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (chain) begin
          if (bcd_q[4*i +: 4] >= 4'd9) begin
            bcd_d[4*i +: 4] = 4'd0;
          end else begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            chain           = 1'b0;
          end
        end
      end
      wrap_d = chain;
    end else if (dn_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (chain) begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            bcd_d[4*i +: 4] = 4'd9;
          end else begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            chain           = 1'b0;
          end
        end
      end
      wrap_d = chain;
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Per-digit segment decode of the registered count.
  always_comb begin
    hex = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter_disp.sv
// Testbench for bcd_updown_counter_disp (2 digits, short debounce/repeat times).
// A monitor pops the expected {bcd, wrap} from a scoreboard queue whenever the
// count changes or wrap is seen; scenario tasks push expectations as they press keys.
module tb_bcd_updown_counter_disp;

  localparam int ND = 2;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

`ifdef HOLD_REPEAT_EN
  localparam int HOLD_STEPS = 6;
`else
  localparam int HOLD_STEPS = 1;
`endif

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          key_up = 1'b1;
  logic          key_dn = 1'b1;
  logic [4*ND-1:0] bcd;
  logic [7*ND-1:0] hex;
  logic          wrap;

  typedef struct packed {
    logic [7:0] bcd;
    logic       wrap;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       mon_e;
  int         errors  = 0;
  int         checks  = 0;
  int         model_v = 0;
  logic [7:0] prev_bcd;

  always #5 clk = ~clk;

  bcd_updown_counter_disp #(
    .NUM_DIGITS     (ND),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key_up(key_up),
    .key_dn(key_dn),
    .bcd   (bcd),
    .hex   (hex),
    .wrap  (wrap)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0:    seg_ref = 7'b1000000;
      4'd1:    seg_ref = 7'b1111001;
      4'd2:    seg_ref = 7'b0100100;
      4'd3:    seg_ref = 7'b0110000;
      4'd4:    seg_ref = 7'b0011001;
      4'd5:    seg_ref = 7'b0010010;
      4'd6:    seg_ref = 7'b0000010;
      4'd7:    seg_ref = 7'b1111000;
      4'd8:    seg_ref = 7'b0000000;
      4'd9:    seg_ref = 7'b0010000;
      default: seg_ref = 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  // Reference model: advance the decimal count and queue the expected output.
  task automatic push_step(input logic up, input logic dn);
    if (up && !dn) begin
      model_v = (model_v + 1) % 100;
      exp_q.push_back('{bcd: to_bcd(model_v), wrap: (model_v == 0)});
    end else if (dn && !up) begin
      model_v = (model_v + 99) % 100;
      exp_q.push_back('{bcd: to_bcd(model_v), wrap: (model_v == 99)});
    end
  endtask

  // Monitor: every observed change (or wrap) must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      prev_bcd = bcd;
    end else if (bcd !== prev_bcd || wrap !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step: got bcd=%h wrap=%b, required no change from %h",
                 bcd, wrap, prev_bcd);
      end else begin
        mon_e = exp_q.pop_front();
        if (bcd !== mon_e.bcd || wrap !== mon_e.wrap ||
            hex !== {seg_ref(mon_e.bcd[7:4]), seg_ref(mon_e.bcd[3:0])}) begin
          errors++;
          $display("FAIL step: got bcd=%h wrap=%b hex=%b, required bcd=%h wrap=%b hex=%b",
                   bcd, wrap, hex, mon_e.bcd, mon_e.wrap,
                   {seg_ref(mon_e.bcd[7:4]), seg_ref(mon_e.bcd[3:0])});
        end
      end
      prev_bcd = bcd;
    end
  end

  // Bounded wait for all queued expectations to be consumed.
  task automatic wait_drain(input string name);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d steps still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic press(input logic up, input logic dn, input int low_cycles);
    @(negedge clk);
    if (up) key_up = 1'b0;
    if (dn) key_dn = 1'b0;
    push_step(up, dn);
    repeat (low_cycles) @(negedge clk);
    key_up = 1'b1;
    key_dn = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bcd !== 8'h00) begin errors++; $display("FAIL reset_bcd: got %h, required 00", bcd); end
    checks++;
    if (hex !== 14'b1000000_1000000) begin
      errors++; $display("FAIL reset_hex: got %b, required 10000001000000", hex);
    end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b, required 0", wrap); end
    rst = 1'b1;
    model_v = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_debounce();
    // Glitch of DB-1 cycles must be rejected.
    @(negedge clk);
    key_up = 1'b0;
    repeat (3) @(negedge clk);
    key_up = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (bcd !== 8'h00) begin errors++; $display("FAIL glitch: got %h, required 00", bcd); end
    // Held press: count changes exactly at edge 2+DB+1 = 7.
    @(negedge clk);
    key_up = 1'b0;
    push_step(1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bcd !== 8'h00) begin errors++; $display("FAIL latency_early: got %h at edge 6, required 00", bcd); end
    @(posedge clk);
    #1;
    checks++;
    if (bcd !== 8'h01) begin errors++; $display("FAIL latency_edge7: got %h, required 01", bcd); end
    repeat (3) @(negedge clk);
    // Bounce on release: short high, low again, then released.
    key_up = 1'b1;
    repeat (2) @(negedge clk);
    key_up = 1'b0;
    repeat (2) @(negedge clk);
    key_up = 1'b1;
    repeat (12) @(negedge clk);
    wait_drain("debounce");
    checks++;
    if (bcd !== 8'h01) begin errors++; $display("FAIL release_bounce: got %h, required 01", bcd); end
  endtask

  task automatic test_carry_borrow();
    repeat (8) press(1'b1, 1'b0, 10);
    checks++;
    if (bcd !== 8'h09) begin errors++; $display("FAIL reach_09: got %h, required 09", bcd); end
    press(1'b1, 1'b0, 10);
    checks++;
    if (bcd !== 8'h10 || hex !== 14'b1111001_1000000) begin
      errors++; $display("FAIL carry: got bcd=%h hex=%b, required 10 / 11110011000000", bcd, hex);
    end
    press(1'b0, 1'b1, 10);
    checks++;
    if (bcd !== 8'h09 || hex !== 14'b1000000_0010000) begin
      errors++; $display("FAIL borrow: got bcd=%h hex=%b, required 09 / 10000000010000", bcd, hex);
    end
    wait_drain("carry");
  endtask

  task automatic test_reset_mid_press();
    @(negedge clk);
    key_up = 1'b0;
    push_step(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bcd !== 8'h00 || hex !== 14'b1000000_1000000 || wrap !== 1'b0) begin
      errors++; $display("FAIL async_reset: got bcd=%h hex=%b wrap=%b, required 00 / 10000001000000 / 0",
                         bcd, hex, wrap);
    end
    model_v = 0;
    wait_drain("pre_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_step(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    key_up = 1'b1;
    repeat (12) @(negedge clk);
    wait_drain("mid_press");
    checks++;
    if (bcd !== 8'h01) begin errors++; $display("FAIL held_after_reset: got %h, required 01", bcd); end
  endtask

  task automatic test_wrap();
    press(1'b0, 1'b1, 10);
    press(1'b0, 1'b1, 10);
    checks++;
    if (bcd !== 8'h99 || wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_down: got bcd=%h wrap=%b, required 99 / 0", bcd, wrap);
    end
    press(1'b1, 1'b0, 10);
    checks++;
    if (bcd !== 8'h00 || wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_up: got bcd=%h wrap=%b, required 00 / 0", bcd, wrap);
    end
    wait_drain("wrap");
  endtask

  task automatic test_simultaneous();
    repeat (42) press(1'b1, 1'b0, 10);
    wait_drain("to_42");
    press(1'b1, 1'b1, 10);
    checks++;
    if (bcd !== 8'h42 || wrap !== 1'b0) begin
      errors++; $display("FAIL simultaneous: got bcd=%h wrap=%b, required 42 / 0", bcd, wrap);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_v = 0;
    @(negedge clk);
    key_up = 1'b0;
    repeat (HOLD_STEPS) push_step(1'b1, 1'b0);
    repeat (60) @(negedge clk);
    key_up = 1'b1;
    repeat (15) @(negedge clk);
    wait_drain("hold");
    checks++;
    if (bcd !== to_bcd(HOLD_STEPS)) begin
      errors++; $display("FAIL hold: got %h, required %h", bcd, to_bcd(HOLD_STEPS));
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_carry_borrow();
    test_reset_mid_press();
    test_wrap();
    test_simultaneous();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
